// File: rtl/sum_tester_pkg.sv
// Shared types and constants for the sum tester tile.
// The optional SUM_TESTER_LOOP_EN build uses REPORT_HOLD to time the
// report phase before the next run starts.
package sum_tester_pkg;

  // Tester phases; ST_DRIVE is the reset state.
  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Feedback taps q[15]^q[13]^q[12]^q[10], shifted left into bit 0.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Power-on LFSR state; must be nonzero or the sequence locks up.
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Report hold length (cycles) when the run loops.
  localparam int REPORT_HOLD = 256;

  // One shift of the operand generator.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sum_tester_if.sv
// Operand/sum bus between the tester (master) and an adder tile (slave).
// The master drives both operands and reads back the sum.
interface sum_tester_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;

  modport master (output a, output b, input sum);
  modport slave  (input a, input b, output sum);
endinterface

// File: rtl/sum_tester_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR. Reset and load both place SEED/seed_i
// in the register; step_i advances one position.
module sum_tester_lfsr16
  import sum_tester_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Load takes priority over step so a reseed is never skipped.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // State register; asynchronous reset returns to the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/tt_um_demo_sum_tester.sv
// Self-running stimulus/checker for an 8-bit adder tile.
// Drives LFSR operand pairs on uo_out/uio_out, checks the returned sum on
// ui_in, then reports error count and status on the same pins.
// Optional macro SUM_TESTER_LOOP_EN: after 256 report cycles the run restarts
// with cleared counters and the LFSR continuing its sequence.
module tt_um_demo_sum_tester
  import sum_tester_pkg::*;
#(
  parameter int          NUM_VECTORS   = 64,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  VEC_LAST    = 9'(NUM_VECTORS - 1);

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] settle_q, settle_d;
  logic [7:0]  err_q, err_d;
  logic [8:0]  vec_q, vec_d;
  logic        ff_seen_q, ff_seen_d;
  logic [5:0]  first_fail_q, first_fail_d;
  logic        lfsr_step;
  logic [15:0] lfsr_q;
  logic        pass;

`ifdef SUM_TESTER_LOOP_EN
  localparam logic [7:0] HOLD_LAST = 8'(REPORT_HOLD - 1);
  logic [7:0]  hold_q, hold_d;
`endif

  // ena and uio_in carry no information for this tile.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in};

  sum_tester_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (lfsr_step),
    .load_i (1'b0),
    .seed_i (LFSR_SEED),
    .q_o    (lfsr_q)
  );

  // Next-state and datapath updates for the drive/settle/sample/report loop.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    exp_d        = exp_q;
    settle_d     = settle_q;
    err_d        = err_q;
    vec_d        = vec_q;
    ff_seen_d    = ff_seen_q;
    first_fail_d = first_fail_q;
    lfsr_step    = 1'b0;
`ifdef SUM_TESTER_LOOP_EN
    hold_d       = hold_q;
`endif
    unique case (state_q)
      ST_DRIVE: begin
        a_d      = lfsr_q[15:8];
        b_d      = lfsr_q[7:0];
        exp_d    = lfsr_q[15:8] + lfsr_q[7:0];
        settle_d = 16'd0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      ST_SAMPLE: begin
        if (ui_in != exp_q) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (!ff_seen_q) begin
            ff_seen_d    = 1'b1;
            first_fail_d = (vec_q > 9'd63) ? 6'd63 : vec_q[5:0];
          end
        end
        lfsr_step = 1'b1;
        vec_d     = vec_q + 9'd1;
        state_d   = (vec_q == VEC_LAST) ? ST_REPORT : ST_DRIVE;
      end
      ST_REPORT: begin
`ifdef SUM_TESTER_LOOP_EN
        if (hold_q == HOLD_LAST) begin
          hold_d       = 8'd0;
          err_d        = 8'd0;
          vec_d        = 9'd0;
          ff_seen_d    = 1'b0;
          first_fail_d = 6'd0;
          state_d      = ST_DRIVE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`else
        // Terminal until reset.
        state_d = ST_REPORT;
`endif
      end
      default: state_d = ST_DRIVE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DRIVE;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      exp_q        <= 8'd0;
      settle_q     <= 16'd0;
      err_q        <= 8'd0;
      vec_q        <= 9'd0;
      ff_seen_q    <= 1'b0;
      first_fail_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      exp_q        <= exp_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      vec_q        <= vec_d;
      ff_seen_q    <= ff_seen_d;
      first_fail_q <= first_fail_d;
    end
  end

`ifdef SUM_TESTER_LOOP_EN
  // Report hold timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // Output mux: operands during a run, report word once the run is over.
  always_comb begin
    pass    = (err_q == 8'd0);
    uo_out  = a_q;
    uio_out = b_q;
    if (state_q == ST_REPORT) begin
      uo_out  = err_q;
      uio_out = {1'b1, pass, pass ? 6'd0 : first_fail_q};
    end
  end

  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_tt_um_demo_sum_tester.sv
// Self-checking bench for tt_um_demo_sum_tester: scoreboarded operand checks
// per vector, table-driven report checks, reset and saturation sequences.
module tb_tt_um_demo_sum_tester;

  localparam int SETTLE = 2;
  localparam int NVEC   = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_drv;
  logic [7:0] uo, uio, oe;
  logic [7:0] uio_in_tie = 8'h00;

  logic [7:0] uo2, uio2, oe2, ui2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sum_tester_if bus ();
  assign bus.a   = uo;
  assign bus.b   = uio;
  assign bus.sum = ui_drv;

  tt_um_demo_sum_tester dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (bus.sum),
    .uo_out  (uo),
    .uio_in  (uio_in_tie),
    .uio_out (uio),
    .uio_oe  (oe)
  );

  // 256-vector instance whose returned sum is always wrong.
  assign ui2 = ~(uo2 + uio2);
  tt_um_demo_sum_tester #(.NUM_VECTORS(256)) dut256 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui2),
    .uo_out  (uo2),
    .uio_in  (uio_in_tie),
    .uio_out (uio2),
    .uio_oe  (oe2)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t       sb[$];
  logic [15:0] m_lfsr;

  typedef struct {
    int         mode;       // 0 ideal, 1 corrupt one vector, 2 tied to zero
    int         bad_idx;
    bit         use_model;  // expected error count comes from the model
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } tcase_t;

  function automatic logic [15:0] lstep(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ui_drv = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  // Push the model's operand pairs, then pop and compare one per vector.
  task automatic run_vectors(input int mode, input int bad_idx, input int n,
                             output int errs, output int first_fail);
    pair_t      p;
    logic [7:0] exp_sum;
    errs = 0;
    first_fail = -1;
    for (int v = 0; v < n; v++) begin
      sb.push_back({m_lfsr[15:8], m_lfsr[7:0]});
      m_lfsr = lstep(m_lfsr);
    end
    @(posedge clk); #1;
    for (int v = 0; v < n; v++) begin
      p = sb.pop_front();
      exp_sum = p.a + p.b;
      chk($sformatf("vec%0d_A", v), bus.a, p.a);
      chk($sformatf("vec%0d_B", v), bus.b, p.b);
      case (mode)
        0:       ui_drv = bus.a + bus.b;
        1:       ui_drv = (v == bad_idx) ? bus.a + bus.b + 8'd1 : bus.a + bus.b;
        default: ui_drv = 8'h00;
      endcase
      if (ui_drv != exp_sum) begin
        errs++;
        if (first_fail < 0) first_fail = v;
      end
      $display("vec %0d: A=%02h B=%02h sum_in=%02h", v, bus.a, bus.b, ui_drv);
      if (v < n - 1) repeat (SETTLE + 2) @(posedge clk);
      else           repeat (SETTLE + 1) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tcase_t tbl[3];
    int errs, ff;
    logic [7:0] exp_uo;

    tbl[0] = '{mode: 0, bad_idx: -1, use_model: 1'b0, exp_uo: 8'h00, exp_uio: 8'hC0};
    tbl[1] = '{mode: 1, bad_idx: 5,  use_model: 1'b0, exp_uo: 8'h01, exp_uio: 8'h85};
    tbl[2] = '{mode: 2, bad_idx: -1, use_model: 1'b1, exp_uo: 8'h00, exp_uio: 8'h80};

    // Reset state.
    rst_n  = 1'b1;
    ui_drv = 8'h00;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_uo", uo, 8'h00);
    chk("reset_uio", uio, 8'h00);
    chk("reset_oe", oe, 8'hFF);

    // Table-driven full runs.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      run_vectors(tbl[t].mode, tbl[t].bad_idx, NVEC, errs, ff);
      if (t == 0) begin
        // Ideal run drives the DUT's own operands back: vector 0 sum.
        chk("first_sum", 8'hAC + 8'hE1, 8'h8D);
      end
      exp_uo = tbl[t].use_model ? ((errs > 255) ? 8'hFF : 8'(errs)) : tbl[t].exp_uo;
      $display("run %0d: report uo=%02h uio=%02h (model errs %0d)", t, uo, uio, errs);
      chk($sformatf("case%0d_report_uo", t), uo, exp_uo);
      chk($sformatf("case%0d_report_uio", t), uio, tbl[t].exp_uio);
      chk($sformatf("case%0d_oe", t), oe, 8'hFF);
    end

    // Reset mid-SETTLE of vector 30.
    do_reset();
    for (int v = 0; v < 30; v++) m_lfsr = lstep(m_lfsr);
    repeat (1 + 4 * 30 + 1) @(posedge clk);
    #1;
    chk("v30_A", uo, m_lfsr[15:8]);
    chk("v30_B", uio, m_lfsr[7:0]);
    rst_n = 1'b0;
    #1;
    $display("mid-reset: uo=%02h uio=%02h oe=%02h", uo, uio, oe);
    chk("midrst_uo", uo, 8'h00);
    chk("midrst_uio", uio, 8'h00);
    chk("midrst_oe", oe, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("restart: A=%02h B=%02h", uo, uio);
    chk("restart_A", uo, 8'hAC);
    chk("restart_B", uio, 8'hE1);
    chk("restart_oe", oe, 8'hFF);

    // 256 vectors, every one wrong: err_cnt saturates.
    do_reset();
    repeat (1030) @(posedge clk);
    #1;
    $display("sat run: uo=%02h uio=%02h", uo2, uio2);
    chk("sat_uo", uo2, 8'hFF);
    chk("sat_uio", uio2, 8'h80);
    chk("sat_oe", oe2, 8'hFF);

`ifdef SUM_TESTER_LOOP_EN
    // Report held exactly 256 cycles, then a fresh run continues the LFSR.
    do_reset();
    run_vectors(0, -1, NVEC, errs, ff);
    chk("loop_rep1_uio", uio, 8'hC0);
    repeat (255) @(posedge clk);
    #1;
    chk("loop_hold_end_uio", uio, 8'hC0);
    chk("loop_hold_end_uo", uo, 8'h00);
    @(posedge clk);
    run_vectors(1, 3, NVEC, errs, ff);
    $display("loop run 2: report uo=%02h uio=%02h", uo, uio);
    chk("loop_rep2_uo", uo, 8'h01);
    chk("loop_rep2_uio", uio, 8'h83);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
